// File: rtl/sudoku_win_checker.sv
// Continuously scans the four board rows through RAM port b and reports whether
// the last undisturbed scan saw a fully solved 4x4 Sudoku.
module sudoku_win_checker #(
    parameter int READ_LATENCY = 1
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        ramWrite,
    output logic [1:0]  ramAddr,
    input  logic [19:0] ramData,
    output logic        scanDone,
    output logic        winInd
);

    localparam logic [1:0] ST_ADDR    = 2'd0;
    localparam logic [1:0] ST_DRAIN   = 2'd1;
    localparam logic [1:0] ST_EVAL    = 2'd2;
    localparam logic [1:0] DRAIN_LAST = 2'(READ_LATENCY - 1);

    logic [1:0]  state_q, state_d;
    logic [1:0]  idx_q, idx_d;
    logic [1:0]  drain_q, drain_d;
    logic        win_q, win_d;
    logic        done_q, done_d;
    logic [19:0] rows_q [4];

    // Tracks which row index each in-flight read belongs to; the oldest entry is the top slot.
    logic [READ_LATENCY-1:0]   pend_vld_q, pend_vld_d;
    logic [2*READ_LATENCY-1:0] pend_idx_q, pend_idx_d;
    logic [READ_LATENCY:0]     vld_shift;
    logic [2*READ_LATENCY+1:0] idx_shift;
    logic                      issue;
    logic [1:0]                cap_idx;

    logic       solved;
    logic [3:0] oh [4][4];
    logic       unused_protect;

    assign ramAddr  = (state_q == ST_ADDR) ? idx_q : 2'd0;
    assign scanDone = done_q;
    assign winInd   = win_q;

    assign issue      = (state_q == ST_ADDR) && !ramWrite;
    assign vld_shift  = {pend_vld_q, issue};
    assign idx_shift  = {pend_idx_q, idx_q};
    assign pend_vld_d = ramWrite ? '0 : vld_shift[READ_LATENCY-1:0];
    assign pend_idx_d = idx_shift[2*READ_LATENCY-1:0];
    assign cap_idx    = pend_idx_q[2*READ_LATENCY-1 -: 2];

    // NOTE: every variable gets a default at the top of the block so no path leaves one unassigned (no latches).
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        drain_d = drain_q;
        win_d   = win_q;
        done_d  = 1'b0;
        if (ramWrite) begin
            state_d = ST_ADDR;
            idx_d   = 2'd0;
            drain_d = 2'd0;
            win_d   = 1'b0;
        end else begin
            case (state_q)
                ST_ADDR: begin
                    idx_d = idx_q + 2'd1;
                    if (idx_q == 2'd3) begin
                        state_d = ST_DRAIN;
                        drain_d = DRAIN_LAST;
                    end
                end
                ST_DRAIN: begin
                    if (drain_q == 2'd0) state_d = ST_EVAL;
                    else                 drain_d = drain_q - 2'd1;
                end
                ST_EVAL: begin
                    state_d = ST_ADDR;
                    idx_d   = 2'd0;
                    win_d   = solved;
                    done_d  = 1'b1;
                end
                default: begin
                    state_d = ST_ADDR;
                    idx_d   = 2'd0;
                end
            endcase
        end
    end

    // Out-of-range values decode to zero, so they can never complete a group.
    always_comb begin
        solved         = 1'b1;
        unused_protect = 1'b0;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                unused_protect = unused_protect ^ rows_q[r][19-5*c];
                case (rows_q[r][15-5*c +: 4])
                    4'd1:    oh[r][c] = 4'b0001;
                    4'd2:    oh[r][c] = 4'b0010;
                    4'd3:    oh[r][c] = 4'b0100;
                    4'd4:    oh[r][c] = 4'b1000;
                    default: oh[r][c] = 4'b0000;
                endcase
                if (oh[r][c] == 4'b0000) solved = 1'b0;
            end
        end
        for (int g = 0; g < 4; g++) begin
            if ((oh[g][0] | oh[g][1] | oh[g][2] | oh[g][3]) != 4'hF) solved = 1'b0;
            if ((oh[0][g] | oh[1][g] | oh[2][g] | oh[3][g]) != 4'hF) solved = 1'b0;
            if ((oh[(g/2)*2][(g%2)*2]   | oh[(g/2)*2][(g%2)*2+1] |
                 oh[(g/2)*2+1][(g%2)*2] | oh[(g/2)*2+1][(g%2)*2+1]) != 4'hF) solved = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so all registers update together at the edge.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q    <= ST_ADDR;
            idx_q      <= 2'd0;
            drain_q    <= 2'd0;
            win_q      <= 1'b0;
            done_q     <= 1'b0;
            pend_vld_q <= '0;
            pend_idx_q <= '0;
            // NOTE: the row store is only four words, so it is reset with everything else rather than left to RAM style.
            for (int r = 0; r < 4; r++) rows_q[r] <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            drain_q    <= drain_d;
            win_q      <= win_d;
            done_q     <= done_d;
            pend_vld_q <= pend_vld_d;
            pend_idx_q <= pend_idx_d;
            if (pend_vld_q[READ_LATENCY-1] && !ramWrite) rows_q[cap_idx] <= ramData;
        end
    end

endmodule
